// File: rtl/sparse_pair_packer.sv
// Packs a stream of sparse positions two per 32-bit word and pads every run to MEM_SPARSE_SIZE words.
// Optional macro DUMMY_RANDOM_EN: pad positions come from a 16-bit LFSR instead of DUMMY_POS.
module sparse_pair_packer #(
  parameter int          WORD_WIDTH      = 32,
  parameter int          MEM_SPARSE_SIZE = 50,
  parameter int          BASE_ADDR       = 0,
  parameter int          N_BITS          = 17669,
  parameter logic [15:0] DUMMY_POS       = 16'd0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [15:0]           pos_in,
  input  logic                  pos_valid,
  input  logic                  pos_last,
  output logic                  pos_ready,
  output logic                  sparse_mem_write_en,
  output logic [9:0]            sparse_mem_addr_o,
  output logic [WORD_WIDTH-1:0] sparse_mem_write_data,
  output logic                  busy,
  output logic                  done,
  output logic [9:0]            real_count,
  output logic                  range_err,
  output logic                  order_err,
  output logic                  overflow
);

  localparam int          IDX_W     = $clog2(MEM_SPARSE_SIZE + 1);
  localparam logic [15:0] N_BITS_16 = 16'(N_BITS);
  localparam logic [9:0]  BASE_10   = 10'(BASE_ADDR);

  typedef enum logic [2:0] {
    S_IDLE, S_COL_HI, S_COL_LO, S_WRITE, S_PAD, S_FIN
  } state_t;

  // Handshake: a position is consumed on a rising edge where pos_valid and pos_ready are both 1.
  state_t           r_state, w_next;
  logic [15:0]      r_high, r_low, r_prev;
  logic             r_have_prev, r_last_seen;
  logic [IDX_W-1:0] r_word_idx;
  logic [9:0]       r_real_count;
  logic             r_range_err, r_order_err, r_overflow;
  logic             w_accept, w_final_word;
  logic [15:0]      w_dummy_a, w_dummy_b;

  assign w_accept     = pos_valid & pos_ready;
  assign w_final_word = (r_word_idx == IDX_W'(MEM_SPARSE_SIZE - 1));

`ifdef DUMMY_RANDOM_EN
  logic [15:0] r_lfsr, w_lfsr_1, w_lfsr_2;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

  // 15-bit draw folded once into range; 32767 - N_BITS is always below N_BITS.
  function automatic logic [15:0] to_pos(input logic [15:0] s);
    logic [15:0] v;
    v = {1'b0, s[14:0]};
    if (v >= N_BITS_16) v = v - N_BITS_16;
    return v;
  endfunction

  assign w_lfsr_1  = lfsr_step(r_lfsr);
  assign w_lfsr_2  = lfsr_step(w_lfsr_1);
  assign w_dummy_a = to_pos(w_lfsr_1);
  assign w_dummy_b = to_pos(w_lfsr_2);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lfsr <= 16'hACE1;
    end else if (r_state == S_IDLE && start) begin
      r_lfsr <= 16'hACE1;
    end else if (r_state == S_COL_HI && w_accept && pos_last) begin
      r_lfsr <= w_lfsr_1;
    end else if (r_state == S_PAD) begin
      r_lfsr <= w_lfsr_2;
    end
  end
`else
  assign w_dummy_a = DUMMY_POS;
  assign w_dummy_b = DUMMY_POS;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next = S_COL_HI;
      S_COL_HI: if (w_accept) w_next = pos_last ? S_WRITE : S_COL_LO;
      S_COL_LO: if (w_accept) w_next = S_WRITE;
      S_WRITE: begin
        if (w_final_word)     w_next = S_FIN;
        else if (r_last_seen) w_next = S_PAD;
        else                  w_next = S_COL_HI;
      end
      S_PAD:    if (w_final_word) w_next = S_FIN;
      S_FIN:    w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    pos_ready             = 1'b0;
    sparse_mem_write_en   = 1'b0;
    sparse_mem_addr_o     = 10'd0;
    sparse_mem_write_data = '0;
    busy                  = 1'b0;
    done                  = 1'b0;
    case (r_state)
      S_COL_HI, S_COL_LO: begin
        pos_ready = 1'b1;
        busy      = 1'b1;
      end
      S_WRITE: begin
        sparse_mem_write_en   = 1'b1;
        sparse_mem_addr_o     = BASE_10 + 10'(r_word_idx);
        sparse_mem_write_data = WORD_WIDTH'({r_high, r_low});
        busy                  = 1'b1;
      end
      S_PAD: begin
        sparse_mem_write_en   = 1'b1;
        sparse_mem_addr_o     = BASE_10 + 10'(r_word_idx);
        sparse_mem_write_data = WORD_WIDTH'({w_dummy_a, w_dummy_b});
        busy                  = 1'b1;
      end
      S_FIN:   done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_high       <= 16'd0;
      r_low        <= 16'd0;
      r_prev       <= 16'd0;
      r_have_prev  <= 1'b0;
      r_last_seen  <= 1'b0;
      r_word_idx   <= '0;
      r_real_count <= 10'd0;
      r_range_err  <= 1'b0;
      r_order_err  <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_word_idx   <= '0;
          r_real_count <= 10'd0;
          r_range_err  <= 1'b0;
          r_order_err  <= 1'b0;
          r_overflow   <= 1'b0;
          r_have_prev  <= 1'b0;
          r_last_seen  <= 1'b0;
        end
        S_COL_HI: if (w_accept) begin
          r_high <= pos_in;
          if (pos_last) begin
            r_low       <= w_dummy_a;
            r_last_seen <= 1'b1;
          end
        end
        S_COL_LO: if (w_accept) begin
          r_low       <= pos_in;
          r_last_seen <= pos_last;
        end
        S_WRITE: begin
          r_word_idx <= r_word_idx + IDX_W'(1);
          if (w_final_word && !r_last_seen) r_overflow <= 1'b1;
        end
        S_PAD:   r_word_idx <= r_word_idx + IDX_W'(1);
        default: ;
      endcase
      // Per-position bookkeeping shared by both collect states.
      if (w_accept) begin
        if (r_real_count != 10'd1023) r_real_count <= r_real_count + 10'd1;
        if (pos_in >= N_BITS_16) r_range_err <= 1'b1;
        if (r_have_prev && pos_in <= r_prev) r_order_err <= 1'b1;
        r_prev      <= pos_in;
        r_have_prev <= 1'b1;
      end
    end
  end

  assign real_count = r_real_count;
  assign range_err  = r_range_err;
  assign order_err  = r_order_err;
  assign overflow   = r_overflow;

endmodule

// File: doc/sparse_pair_packer.md
Name: sparse_pair_packer

Overview:
- Upstream feeder of the sparse-times-dense polynomial controller.
- Accepts a stream of sparse bit positions and packs them two per word ({high[31:16], low[15:0]}) into sparse memory.
- Pads unused entries with dummy positions so that every run writes exactly MEM_SPARSE_SIZE words, giving constant-time, weight-independent processing downstream.
- Pulses done when sparse memory is fully loaded; done can drive the controller's start_process.

Parameters:
- WORD_WIDTH, 32, sparse memory word width; fixed at 32 (two 16-bit positions per word).
- MEM_SPARSE_SIZE, 50, number of sparse memory words written per run.
- BASE_ADDR, 0, first sparse memory address written.
- N_BITS, 17669, polynomial length; valid positions are 0..N_BITS-1; must be > 16384.
- DUMMY_POS, 16'd0, fixed dummy position used when DUMMY_RANDOM_EN is undefined.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse, begins a run; ignored unless idle
- pos_in  in  16  sparse position
- pos_valid  in  1  pos_in valid
- pos_last  in  1  marks the final real position, qualified by pos_valid
- pos_ready  out  1  block accepts pos_in this cycle
- sparse_mem_write_en  out  1  write strobe
- sparse_mem_addr_o  out  10  write address
- sparse_mem_write_data  out  32  {high_pos, low_pos}
- busy  out  1  run in progress
- done  out  1  one-cycle pulse, all words written
- real_count  out  10  real positions accepted in the last run
- range_err  out  1  sticky: a position >= N_BITS was accepted
- order_err  out  1  sticky: a position was <= its predecessor
- overflow  out  1  sticky: sparse memory filled before pos_last was accepted

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - State goes to IDLE.
  - All outputs 0, and all counters and error flags 0.
  - A reset mid-run aborts with no further writes and no done pulse.
- States:
  - IDLE: on start, go to COL_HI; set busy=1; clear word_idx, real_count and all error flags.
  - COL_HI: pos_ready=1. On acceptance (pos_valid & pos_ready), latch high=pos_in and increment real_count.
    - pos_last=0: go to COL_LO.
    - pos_last=1: set low=dummy and go to WRITE.
  - COL_LO: pos_ready=1. On acceptance, latch low=pos_in, increment real_count, and go to WRITE. Set pos_last_seen=pos_last.
  - WRITE: pos_ready=0. Registered outputs: we=1, addr=BASE_ADDR+word_idx, data={high,low}. Then increment word_idx.
    - word_idx+1 == MEM_SPARSE_SIZE: go to FIN. If last has not been accepted, set overflow=1.
    - Otherwise, if last has been accepted: go to PAD.
    - Otherwise: go to COL_HI.
  - PAD: pos_ready=0. Write {dummy,dummy} at BASE_ADDR+word_idx, one word per cycle, incrementing word_idx, until MEM_SPARSE_SIZE words are written. Then go to FIN.
  - FIN: we=0, done=1 for one cycle, busy=0, then IDLE.
- pos_ready is a combinational decode of the state: 1 only in COL_HI or COL_LO.
- Write latency: the write appears exactly 1 cycle after the low half (or the last high half) is accepted.
- A run with no real positions is not possible: pos_last is required on some position.
- Each write_en pulse lasts exactly 1 cycle; each address is written exactly once per run, in ascending order.
- Checks on every accepted position:
  - pos_in >= N_BITS sets range_err. The value is still written unmodified.
  - Any position after the first that is <= the previous accepted position sets order_err.
  - Errors never stop the run.
- Overflow: after MEM_SPARSE_SIZE words are written, the block stops accepting input; remaining upstream data is left unconsumed.
- start while busy is ignored.
- real_count is 10 bits and saturates at 1023; it holds its value until the next start.
- Total run length: ceil(real/2) write cycles + pad cycles + accept cycles + 1 FIN cycle. The number of write cycles per run is exactly MEM_SPARSE_SIZE.

Optional Feature:
- Macro: DUMMY_RANDOM_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1) seeded with 16'hACE1 on reset and on start supplies each dummy.
  - Dummy value = lfsr[14:0], minus N_BITS if >= N_BITS. This is always < N_BITS.
  - The LFSR advances once per dummy consumed, so a padded word uses two successive values (high first).
- Undefined: every dummy = DUMMY_POS, and no LFSR logic is present.

Test Plan:
- Reset, then 4 positions 10, 200, 3000, 17000 (last on 17000) -> writes addr0={10,200}, addr1={3000,17000}, addr2..49={DUMMY_POS,DUMMY_POS}; done pulse; real_count=4; no error flags.
- 3 positions 5, 6, 7 (last on 7) -> addr0={5,6}, addr1={7,DUMMY_POS}, 48 pad words; exactly 50 write strobes total.
- 100 ascending positions 0,2,...,198, with last on the 100th -> 50 real words, no PAD, overflow=0. Repeat with 102 positions -> overflow=1, pos_ready=0 after the 100th, positions 101-102 never accepted.
- Positions 100, 50, 20000 -> order_err=1 and range_err=1, all three values still written verbatim, done still pulses.
- Assert rst during PAD at word 20 -> outputs 0 next cycle, no done. A following start and a 2-position run -> clean 50-word write sequence from BASE_ADDR.
- With DUMMY_RANDOM_EN, 1 position 0 -> addr0={0,d0}, where d0 is derived from the first LFSR step after seed ACE1; all pad values < 17669; a second identical run gives an identical pad sequence.
